sid_voice_ext: RTL and testbench

SID_VOICE_EXT -- requirements
Module: sid_voice_ext

---
 rtl/sid_voice_ext.sv | 129 ++++++++++++
 tb/tb_sid_voice_ext.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sid_voice_ext.sv
// SID-style voice: phase accumulator, noise LFSR, waveform mixer and envelope scaling.
// Define SID_VOICE_RING_MOD_EN to enable ring modulation of the triangle fold.
module sid_voice_ext #(
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned FREQ_W = 16,
    parameter int unsigned PW_W   = 12,
    parameter int unsigned OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [FREQ_W-1:0] frequency,
    input  logic [PW_W-1:0]   pulse_width,
    input  logic [7:0]        waveform,
    input  logic [7:0]        envelope,
    input  logic              msb_in,
    output logic [OUT_W-1:0]  voice,
    output logic              voice_valid,
    output logic              msb_out
);

    localparam int unsigned LFSR_W   = 23;
    localparam int unsigned NOISE_CK = ACC_W - 5;
    localparam int unsigned MUL_W    = OUT_W + 8;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 23'h7FFFF8;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              msb_in_prev_q, msb_in_prev_d;
    logic              lfsr_clk_q, lfsr_clk_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [OUT_W-1:0]  wave_q, wave_d;
    logic [OUT_W-1:0]  voice_q, voice_d;
    logic              valid_q, valid_d;
    logic              primed_q, primed_d;

    logic              fold_c;
    logic              sync_edge_c;
    logic [OUT_W-1:0]  saw_c, tri_c, pulse_c, noise_c, mix_c;
    logic [7:0]        noise8_c;
    logic [OUT_W+7:0]  noise_ext_c;
    logic [MUL_W-1:0]  prod_c;
    logic              unused_c;

    // Waveform generators and OR mixer, all from the current accumulator/LFSR state
    always_comb begin
`ifdef SID_VOICE_RING_MOD_EN
        fold_c = acc_q[ACC_W-1] ^ (waveform[2] & msb_in);
`else
        fold_c = acc_q[ACC_W-1];
`endif
        if (waveform[5]) begin
            fold_c = 1'b0;
        end
        saw_c    = acc_q[ACC_W-1 -: OUT_W];
        tri_c    = acc_q[ACC_W-2 -: OUT_W] ^ {OUT_W{fold_c}};
        pulse_c  = {OUT_W{acc_q[ACC_W-1 -: PW_W] >= pulse_width}};
        noise8_c = {lfsr_q[22], lfsr_q[20], lfsr_q[16], lfsr_q[13],
                    lfsr_q[11], lfsr_q[7],  lfsr_q[4],  lfsr_q[2]};
        // MSB-align the 8-bit noise sample, truncating when OUT_W < 8
        noise_ext_c = {noise8_c, OUT_W'(0)};
        noise_c     = noise_ext_c[OUT_W+7 -: OUT_W];
        mix_c = '0;
        if (waveform[7]) mix_c = mix_c | noise_c;
        if (waveform[6]) mix_c = mix_c | pulse_c;
        if (waveform[5]) mix_c = mix_c | saw_c;
        if (waveform[4]) mix_c = mix_c | tri_c;
        sync_edge_c = waveform[1] & msb_in & ~msb_in_prev_q;
        prod_c      = MUL_W'(wave_q) * MUL_W'(envelope);
    end

    assign unused_c = ^{waveform[0], waveform[2], prod_c[7:0]};

    // Next-state: everything holds unless ce; test clears phase, noise and priming
    always_comb begin
        acc_d         = acc_q;
        msb_in_prev_d = msb_in_prev_q;
        lfsr_clk_d    = lfsr_clk_q;
        lfsr_d        = lfsr_q;
        wave_d        = wave_q;
        voice_d       = voice_q;
        valid_d       = 1'b0;
        primed_d      = primed_q;
        if (ce) begin
            msb_in_prev_d = msb_in;
            lfsr_clk_d    = acc_q[NOISE_CK];
            if (waveform[3]) begin
                acc_d    = '0;
                lfsr_d   = LFSR_SEED;
                primed_d = 1'b0;
            end else begin
                acc_d = sync_edge_c ? '0 : acc_q + ACC_W'(frequency);
                if (acc_q[NOISE_CK] && !lfsr_clk_q) begin
                    lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[22] ^ lfsr_q[17]};
                end
                wave_d   = mix_c;
                voice_d  = prod_c[MUL_W-1:8];
                valid_d  = primed_q;
                primed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q         <= '0;
            msb_in_prev_q <= 1'b0;
            lfsr_clk_q    <= 1'b0;
            lfsr_q        <= LFSR_SEED;
            wave_q        <= '0;
            voice_q       <= '0;
            valid_q       <= 1'b0;
            primed_q      <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            msb_in_prev_q <= msb_in_prev_d;
            lfsr_clk_q    <= lfsr_clk_d;
            lfsr_q        <= lfsr_d;
            wave_q        <= wave_d;
            voice_q       <= voice_d;
            valid_q       <= valid_d;
            primed_q      <= primed_d;
        end
    end

    assign voice       = voice_q;
    assign voice_valid = valid_q;
    assign msb_out     = acc_q[ACC_W-1];

endmodule

// File: tb/tb_sid_voice_ext.sv
// Randomized bench for sid_voice_ext against an arithmetic reference model (default parameters).
module tb_sid_voice_ext;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [15:0] frequency;
    logic [11:0] pulse_width;
    logic [7:0]  waveform;
    logic [7:0]  envelope;
    logic        msb_in;
    logic [7:0]  voice;
    logic        voice_valid;
    logic        msb_out;

    int n_vec = 0;
    int n_err = 0;

    sid_voice_ext dut (
        .clk(clk), .rst(rst), .ce(ce), .frequency(frequency),
        .pulse_width(pulse_width), .waveform(waveform), .envelope(envelope),
        .msb_in(msb_in), .voice(voice), .voice_valid(voice_valid), .msb_out(msb_out)
    );

    always #5 clk = ~clk;

    localparam int unsigned SEED = 32'h7FFFF8;

    // Reference state: phase, noise register, and the two pipeline samples
    int unsigned m_acc;
    int unsigned m_lfsr;
    bit          m_prev, m_lclk, m_valid, m_primed;
    int          m_wave, m_voice;

    function automatic int noise_of(input int unsigned l);
        int taps [8] = '{22, 20, 16, 13, 11, 7, 4, 2};
        int r = 0;
        for (int i = 0; i < 8; i++) r = r * 2 + int'((l >> taps[i]) & 1);
        return r;
    endfunction

    function automatic int wave_of(input int unsigned acc, input int unsigned l,
                                   input logic [7:0] w, input int pw, input bit mi);
        int saw  = int'(acc / 65536);
        int traw = int'((acc / 32768) % 256);
        bit fold = (acc >= 32'h800000);
        int tri_v, pul, r;
`ifdef SID_VOICE_RING_MOD_EN
        if (w[2]) fold = fold ^ mi;
`endif
        if (w[5]) fold = 1'b0;
        tri_v = fold ? 255 - traw : traw;
        pul   = (int'(acc / 4096) >= pw) ? 255 : 0;
        r = 0;
        if (w[7]) r = r | noise_of(l);
        if (w[6]) r = r | pul;
        if (w[5]) r = r | saw;
        if (w[4]) r = r | tri_v;
        return r;
    endfunction

    task automatic model_step();
        bit b;
        int nw;
        if (rst) begin
            m_acc = 0; m_prev = 0; m_lclk = 0; m_lfsr = SEED;
            m_wave = 0; m_voice = 0; m_valid = 0; m_primed = 0;
        end else if (!ce) begin
            m_valid = 0;
        end else begin
            b = bit'((m_acc >> 19) & 1);
            if (waveform[3]) begin
                m_acc = 0; m_lfsr = SEED; m_primed = 0; m_valid = 0;
            end else begin
                nw       = wave_of(m_acc, m_lfsr, waveform, int'(pulse_width), msb_in);
                m_voice  = (m_wave * int'(envelope)) / 256;
                m_valid  = m_primed;
                m_primed = 1;
                m_wave   = nw;
                if (b && !m_lclk)
                    m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 22) ^ (m_lfsr >> 17)) & 1)) & 32'h7FFFFF;
                if (waveform[1] && msb_in && !m_prev) m_acc = 0;
                else m_acc = (m_acc + int'(frequency)) % 32'h1000000;
            end
            m_lclk = b;
            m_prev = msb_in;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("voice", int'(voice), m_voice);
        check("voice_valid", int'(voice_valid), int'(m_valid));
        check("msb_out", int'(msb_out), int'(m_acc >= 32'h800000));
    endtask

    // One clock: sample just after the edge, advance the model, compare
    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; frequency = '0; pulse_width = '0;
        waveform = '0; envelope = '0; msb_in = 1'b0;
        cycle();
        cycle();
        check("reset_voice", int'(voice), 0);
        check("reset_valid", int'(voice_valid), 0);
        check("reset_msb_out", int'(msb_out), 0);

        // Saw ramp: voice steps every 16 steps, first valid on step 2
        rst = 1'b0; ce = 1'b1; frequency = 16'h1000; waveform = 8'h20; envelope = 8'hFF;
        for (int n = 1; n <= 82; n++) begin
            cycle();
            if (n == 1)  check("saw_first_valid_low", int'(voice_valid), 0);
            if (n == 2)  check("saw_first_valid_high", int'(voice_valid), 1);
            if (n == 34) check("saw_step34", int'(voice), 1);
            if (n == 82) check("saw_step82", int'(voice), 4);
        end

        // Asynchronous reset clears outputs before the next edge
        rst = 1'b1;
        #2;
        check("async_rst_voice", int'(voice), 0);
        check("async_rst_valid", int'(voice_valid), 0);
        check("async_rst_msb", int'(msb_out), 0);
        cycle();
        rst = 1'b0;

        // Pulse threshold crossing at acc = 0x800000
        frequency = 16'h8000; waveform = 8'h40; pulse_width = 12'h800; envelope = 8'hFF;
        for (int n = 1; n <= 260; n++) begin
            cycle();
            if (n == 257) check("pulse_below", int'(voice), 8'h00);
            if (n == 258) check("pulse_above", int'(voice), 8'hFE);
        end

        // Noise from seed: sample 0xFE scaled by 0xFF
        do_reset();
        frequency = 16'h0000; waveform = 8'h80; envelope = 8'hFF;
        cycle();
        cycle();
        check("noise_seed_voice", int'(voice), 8'hFD);

        // Test bit for 3 steps: voice holds, valid drops, then re-primes
        waveform = 8'h88; frequency = 16'h1234;
        for (int n = 0; n < 3; n++) cycle();
        check("test_voice_hold", int'(voice), 8'hFD);
        check("test_valid_low", int'(voice_valid), 0);
        check("test_msb_low", int'(msb_out), 0);
        waveform = 8'h80;
        cycle();
        check("test_recover_step1", int'(voice_valid), 0);
        cycle();
        check("test_recover_step2", int'(voice_valid), 1);

        // Hard sync: saw + sync, source msb toggling every 100 steps
        do_reset();
        frequency = 16'h0123; waveform = 8'h22; envelope = 8'hC3;
        for (int n = 0; n < 600; n++) begin
            if (n % 100 == 0) msb_in = ~msb_in;
            cycle();
        end

        // Long noise run: ~1000 LFSR shifts on acc[19] edges
        do_reset();
        msb_in = 1'b0; frequency = 16'hFFFF; waveform = 8'h80;
        for (int n = 0; n < 16200; n++) begin
            envelope = 8'($urandom);
            cycle();
        end

        // Fully randomized controls
        for (int n = 0; n < 4000; n++) begin
            rst         = ($urandom % 300 == 0);
            ce          = ($urandom % 8 != 0);
            frequency   = 16'($urandom);
            pulse_width = 12'($urandom);
            envelope    = 8'($urandom);
            waveform    = 8'($urandom);
            waveform[3] = ($urandom % 32 == 0);
            if ($urandom % 16 == 0) msb_in = ~msb_in;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
